// File: rtl/ps_pl_pkg.sv
// Shared types and constants for the PS-PL link reader side.
package ps_pl_pkg;

    // Packer FSM: FILL collects lanes, HOLD presents a closed word.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Width of the accepted-word counter.
    localparam int WORDS_SENT_W = 16;

    // Width of a lane index for a word of 'bytes' lanes.
    function automatic int lane_idx_w(input int bytes);
        return (bytes < 2) ? 1 : $clog2(bytes);
    endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle timer: counts enabled cycles and flags the cycle in which the count
// reaches TIMEOUT. A TIMEOUT of 0 disables the timer entirely.
module fifo_idle_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;

            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clear_i, enable_i};
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT + 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next count: clear wins, otherwise count up while enabled, saturating at TIMEOUT.
            always_comb begin
                // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Count register.
            always_ff @(posedge clk or posedge rst) begin
                // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Fires in the idle cycle whose edge brings the count to TIMEOUT.
            assign expired_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/fifo_word_packer.sv
// Pops narrow FIFO entries and packs BYTES of them (lane 0 first) into one
// wide word, presented on a valid/ready master port. Partial words are closed
// by an explicit flush or an idle timeout and carry a lane-keep mask.
module fifo_word_packer
    import ps_pl_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_valid,
    input  logic [IN_W-1:0]         fifo_data,
    output logic                    fifo_enr,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [IN_W*BYTES-1:0]   m_data,
    output logic [BYTES-1:0]        m_keep,
    output logic                    m_last,
    output logic [WORDS_SENT_W-1:0] words_sent
);

    localparam int OUT_W = IN_W * BYTES;
    localparam int IDX_W = lane_idx_w(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [OUT_W-1:0]        data_q, data_d;
    logic [BYTES-1:0]        keep_q, keep_d;
    logic                    last_q, last_d;
    logic [WORDS_SENT_W-1:0] sent_q, sent_d;

    logic pop;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    // Pop whenever filling and the FIFO has data; gated by rst so the request
    // drops the instant reset is asserted, not at the next edge.
    assign pop      = (state_q == ST_FILL) && fifo_valid && !rst;
    assign fifo_enr = pop;

    // The idle count runs only while a partial word waits for more data.
    assign timer_en    = (state_q == ST_FILL) && !pop && (idx_q != '0);
    assign timer_clear = pop || (state_q == ST_HOLD) || (idx_q == '0);

    fifo_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state logic: lane capture and word close in FILL, handshake in HOLD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        sent_d  = sent_q;

        unique case (state_q)
            ST_FILL: begin
                if (pop) begin
                    // The popped entry always lands first; flush then closes whatever is there.
                    data_d[int'(idx_q) * IN_W +: IN_W] = fifo_data;
                    keep_d[idx_q]                      = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                        last_d  = flush;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (flush) begin
                            state_d = ST_HOLD;
                            last_d  = 1'b1;
                        end
                    end
                end else if ((flush || timer_expired) && (idx_q != '0)) begin
                    // Close a partial word; an empty word is never emitted.
                    state_d = ST_HOLD;
                    last_d  = 1'b1;
                end
            end

            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    sent_d  = sent_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            sent_q  <= sent_d;
        end
    end

    // Lanes not yet written stay zero because data is cleared on every accept.
    assign m_valid    = (state_q == ST_HOLD);
    assign m_data     = data_q;
    assign m_keep     = keep_q;
    assign m_last     = last_q;
    assign words_sent = sent_q;

endmodule
